// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   scan_state_t  : scanner FSM states (SCAN, CONFIRM, HELD)
//   keymap()      : (row, col) -> 4-bit hex key code
//   col_decode()  : column index -> one-hot-low column strobe
//   single_zero() : true when a row pattern has exactly one low bit
//   zero_pos()    : index of the low bit in a single-zero pattern
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2
    } scan_state_t;

    // Physical layout:
    //   r0: 1 2 3 A
    //   r1: 4 5 6 B
    //   r2: 7 8 9 C
    //   r3: * 0 # D   (* = E, # = F)
    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] col_decode(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    // Exactly one zero: the inverted pattern is non-zero and a power of two.
    function automatic logic single_zero(input logic [3:0] rs);
        logic [3:0] z;
        z = ~rs;
        return (z != 4'd0) && ((z & (z - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] zero_pos(input logic [3:0] rs);
        logic [1:0] p;
        casez (rs)
            4'b???0: p = 2'd0;
            4'b??01: p = 2'd1;
            4'b?011: p = 2'd2;
            default: p = 2'd3;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows.
//   clk   : system clock
//   reset : synchronous active-high reset, both flops go to 4'b1111 (no key)
//   row   : raw active-low rows
//   rs    : synchronized rows (second flop)
module keypad_row_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] rs
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 4'b1111;
            rs   <= 4'b1111;
        end else begin
            meta <= row;
            rs   <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner with debounce.
// Drives one column low at a time for SCAN_DIV cycles and samples the
// synchronized rows on the last dwell cycle. A single-zero pattern locks the
// column, must repeat for DEBOUNCE_CNT samples to confirm, and must then read
// all-high for DEBOUNCE_CNT consecutive samples to release.
//   clk       : system clock
//   reset     : synchronous active-high reset
//   row       : keypad rows, active-low, asynchronous
//   col       : column strobes, active-low one-hot
//   key_code  : hex code of the last confirmed key
//   key_valid : one-cycle pulse on a confirmed press
//   key_held  : high while the confirmed key stays pressed
module keypad_scan_4x4
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int MW = $clog2(DEBOUNCE_CNT + 1);

    logic [3:0]    rs;
    scan_state_t   state, state_n;
    logic [DW-1:0] dwell, dwell_n;
    // While locked (CONFIRM/HELD) col_idx is the candidate column.
    logic [1:0]    col_idx, col_idx_n;
    logic [1:0]    cand_row, cand_row_n;
    logic [3:0]    pat, pat_n;
    logic [MW-1:0] match, match_n;
    logic [MW-1:0] rel, rel_n;
    logic [3:0]    key_code_n;
    logic          key_valid_n, key_held_n;
    logic          sample;

    keypad_row_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .row   (row),
        .rs    (rs)
    );

    assign sample = (dwell == DW'(SCAN_DIV - 1));
    assign col    = col_decode(col_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            dwell     <= '0;
            col_idx   <= 2'd0;
            cand_row  <= 2'd0;
            pat       <= 4'b1111;
            match     <= '0;
            rel       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            dwell     <= dwell_n;
            col_idx   <= col_idx_n;
            cand_row  <= cand_row_n;
            pat       <= pat_n;
            match     <= match_n;
            rel       <= rel_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            key_held  <= key_held_n;
        end
    end

    always_comb begin
        state_n     = state;
        dwell_n     = sample ? '0 : dwell + DW'(1);
        col_idx_n   = col_idx;
        cand_row_n  = cand_row;
        pat_n       = pat;
        match_n     = match;
        rel_n       = rel;
        key_code_n  = key_code;
        key_valid_n = 1'b0;
        key_held_n  = key_held;

        if (sample) begin
            unique case (state)
                SCAN: begin
                    if (single_zero(rs)) begin
                        cand_row_n = zero_pos(rs);
                        pat_n      = rs;
                        match_n    = MW'(1);
                        state_n    = CONFIRM;
                    end else begin
                        col_idx_n = col_idx + 2'd1;
                    end
                end
                CONFIRM: begin
                    if (rs == pat) begin
                        if (match == MW'(DEBOUNCE_CNT - 1)) begin
                            state_n     = HELD;
                            match_n     = '0;
                            rel_n       = '0;
                            key_code_n  = keymap(cand_row, col_idx);
                            key_valid_n = 1'b1;
                            key_held_n  = 1'b1;
                        end else begin
                            match_n = match + MW'(1);
                        end
                    end else begin
                        match_n   = '0;
                        state_n   = SCAN;
                        col_idx_n = col_idx + 2'd1;
                    end
                end
                HELD: begin
                    // Only an unbroken run of all-high samples releases.
                    if (rs == 4'b1111) begin
                        if (rel == MW'(DEBOUNCE_CNT - 1)) begin
                            rel_n      = '0;
                            key_held_n = 1'b0;
                            state_n    = SCAN;
                            col_idx_n  = col_idx + 2'd1;
                        end else begin
                            rel_n = rel + MW'(1);
                        end
                    end else begin
                        rel_n = '0;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

endmodule
